// File: rtl/cmos_pkg.sv
// Shared types and constants for the CMOS camera-stream stages.
// Provides the frame FSM state enum, stream widths and the adaptive threshold helper.
package cmos_pkg;

    localparam int PIX_W          = 8;
    localparam int X_W            = 11;
    localparam int Y_W            = 10;
    localparam int THRESH_NUM_DEF = 192;
    localparam int MIN_THRESH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Scales the frame peak by num/256 and clamps the result to a floor.
    function automatic logic [PIX_W-1:0] calcThresh(input logic [PIX_W-1:0] maxVal,
                                                    input logic [15:0]      num,
                                                    input logic [PIX_W-1:0] minVal);
        logic [15:0] t;
        t = ({8'd0, maxVal} * num) >> 8;
        return (t < {8'd0, minVal}) ? minVal : t[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Registered rise/fall detector for camera sync strobes (vsync, href).
// o_dly is the one-cycle registered copy; edges compare the live input against it.
module sync_edge_det #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_sig,
    output logic [W-1:0] o_dly,
    output logic [W-1:0] o_rise,
    output logic [W-1:0] o_fall
);

    logic [W-1:0] r_dly;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dly <= '0;
        end else begin
            r_dly <= i_sig;
        end
    end

    assign o_dly  = r_dly;
    assign o_rise = i_sig & ~r_dly;
    assign o_fall = ~i_sig & r_dly;

endmodule

// File: rtl/frame_thresh_binarize.sv
// Adaptive-threshold binarizer with per-frame bright-pixel count (2-cycle pipeline).
// Optional macro BBOX_EN adds a per-frame bounding box of bright pixels.
module frame_thresh_binarize
    import cmos_pkg::*;
#(
    parameter int THRESH_NUM = THRESH_NUM_DEF,
    parameter int MIN_THRESH = MIN_THRESH_DEF,
    parameter int CNT_W      = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PIX_W-1:0] indata,
    input  logic             cmos_frame_href,
    input  logic             cmos_frame_vsync,
    input  logic [PIX_W-1:0] max_data,
    output logic             bin_data,
    output logic             bin_href,
    output logic             bin_vsync,
    output logic [PIX_W-1:0] thresh,
    output logic [CNT_W-1:0] bright_cnt,
`ifdef BBOX_EN
    output logic [X_W-1:0]   bbox_xmin,
    output logic [X_W-1:0]   bbox_xmax,
    output logic [Y_W-1:0]   bbox_ymin,
    output logic [Y_W-1:0]   bbox_ymax,
`endif
    output logic             frame_done
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       w_syncDly;
    logic [1:0]       w_syncRise;
    logic [1:0]       w_syncFall;
    logic             w_vsRise;
    logic             w_vsFall;
    logic             w_hrefD1;
    logic             w_vsD1;

    state_t           r_state;
    logic [PIX_W-1:0] r_pixD1;
    logic             r_binData;
    logic             r_binHref;
    logic             r_binVsync;
    logic [PIX_W-1:0] r_thresh;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_brightCnt;
    logic             r_frameDone;

    // Bit 1 is vsync, bit 0 is href; the delayed copies double as stage-1 sync registers.
    sync_edge_det #(.W(2)) u_syncEdge (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_sig  ({cmos_frame_vsync, cmos_frame_href}),
        .o_dly  (w_syncDly),
        .o_rise (w_syncRise),
        .o_fall (w_syncFall)
    );

    assign w_vsRise = w_syncRise[1];
    assign w_vsFall = w_syncFall[1];
    assign w_vsD1   = w_syncDly[1];
    assign w_hrefD1 = w_syncDly[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pixD1    <= '0;
            r_binData  <= 1'b0;
            r_binHref  <= 1'b0;
            r_binVsync <= 1'b0;
        end else begin
            r_pixD1    <= indata;
            r_binData  <= w_hrefD1 && (r_pixD1 >= r_thresh) && (r_state != IDLE);
            r_binHref  <= w_hrefD1 && (r_state != IDLE);
            r_binVsync <= w_vsD1;
        end
    end

    // Frame FSM; threshold latches on every vsync rise, count publishes in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_thresh    <= PIX_W'(MIN_THRESH);
            r_cnt       <= '0;
            r_brightCnt <= '0;
            r_frameDone <= 1'b0;
        end else begin
            r_frameDone <= 1'b0;
            if (w_vsRise) begin
                r_thresh <= calcThresh(max_data, 16'(THRESH_NUM), PIX_W'(MIN_THRESH));
            end
            case (r_state)
                IDLE: begin
                    if (w_vsRise) r_state <= SYNC;
                end
                SYNC: begin
                    if (w_vsFall) r_state <= ACTIVE;
                end
                ACTIVE: begin
                    if (r_binData && (r_cnt != CNT_MAX)) r_cnt <= r_cnt + 1'b1;
                    if (w_vsRise) r_state <= DONE;
                end
                DONE: begin
                    r_brightCnt <= r_cnt;
                    r_frameDone <= 1'b1;
                    r_cnt       <= '0;
                    r_state     <= w_vsFall ? ACTIVE : SYNC;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bin_data   = r_binData;
    assign bin_href   = r_binHref;
    assign bin_vsync  = r_binVsync;
    assign thresh     = r_thresh;
    assign bright_cnt = r_brightCnt;
    assign frame_done = r_frameDone;

`ifdef BBOX_EN
    logic           w_hrefFall;
    logic           w_unused;
    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    logic [X_W-1:0] r_xD1;
    logic [Y_W-1:0] r_yD1;
    logic [X_W-1:0] r_xD2;
    logic [Y_W-1:0] r_yD2;
    logic [X_W-1:0] r_runXmin;
    logic [X_W-1:0] r_runXmax;
    logic [Y_W-1:0] r_runYmin;
    logic [Y_W-1:0] r_runYmax;
    logic [X_W-1:0] r_xmin;
    logic [X_W-1:0] r_xmax;
    logic [Y_W-1:0] r_ymin;
    logic [Y_W-1:0] r_ymax;

    assign w_hrefFall = w_syncFall[0];
    assign w_unused   = w_syncRise[0];

    // Coordinates travel alongside the pixel so stage 2 sees the coordinate of its own pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x   <= '0;
            r_y   <= '0;
            r_xD1 <= '0;
            r_yD1 <= '0;
            r_xD2 <= '0;
            r_yD2 <= '0;
        end else begin
            if (w_hrefFall) r_x <= '0;
            else if (cmos_frame_href) r_x <= r_x + 1'b1;
            if (w_vsRise) r_y <= '0;
            else if (w_hrefFall) r_y <= r_y + 1'b1;
            r_xD1 <= r_x;
            r_yD1 <= r_y;
            r_xD2 <= r_xD1;
            r_yD2 <= r_yD1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_runXmin <= '1;
            r_runXmax <= '0;
            r_runYmin <= '1;
            r_runYmax <= '0;
            r_xmin    <= '0;
            r_xmax    <= '0;
            r_ymin    <= '0;
            r_ymax    <= '0;
        end else if (r_state == DONE) begin
            r_xmin    <= r_runXmin;
            r_xmax    <= r_runXmax;
            r_ymin    <= r_runYmin;
            r_ymax    <= r_runYmax;
            r_runXmin <= '1;
            r_runXmax <= '0;
            r_runYmin <= '1;
            r_runYmax <= '0;
        end else if ((r_state == ACTIVE) && r_binData) begin
            if (r_xD2 < r_runXmin) r_runXmin <= r_xD2;
            if (r_xD2 > r_runXmax) r_runXmax <= r_xD2;
            if (r_yD2 < r_runYmin) r_runYmin <= r_yD2;
            if (r_yD2 > r_runYmax) r_runYmax <= r_yD2;
        end
    end

    assign bbox_xmin = r_xmin;
    assign bbox_xmax = r_xmax;
    assign bbox_ymin = r_ymin;
    assign bbox_ymax = r_ymax;
`else
    logic w_unused;
    assign w_unused = ^{w_syncRise[0], w_syncFall[0]};
`endif

endmodule

// File: tb/tb_frame_thresh_binarize.sv
// Scoreboard bench for frame_thresh_binarize: default DUT plus a CNT_W=4 copy for saturation.
// Bbox checks are compiled in when BBOX_EN is defined.
module tb_frame_thresh_binarize;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] indata;
    logic       href;
    logic       vsync;
    logic [7:0] maxData;

    logic        binData, binHref, binVsync, frameDone;
    logic [7:0]  threshOut;
    logic [19:0] brightCnt;
    logic        binData4, binHref4, binVsync4, frameDone4;
    logic [7:0]  threshOut4;
    logic [3:0]  brightCnt4;
`ifdef BBOX_EN
    logic [10:0] bxMin, bxMax, bxMin4, bxMax4;
    logic [9:0]  byMin, byMax, byMin4, byMax4;
`endif

    int errors = 0;
    int checks = 0;
    int doneSeen = 0;
    int pushCount = 0;

    bit expBinQ[$];
    int expCntQ[$];
    int expCnt4Q[$];
    int expBoxQ[$];

    int mState;
    int mThresh;
    int mCount;
    int mxMin, mxMax, myMin, myMax;
    bit [1:0] vsHist;

    always #5 clk = ~clk;

    frame_thresh_binarize dut (
        .clk(clk), .rst_n(rst_n), .indata(indata), .cmos_frame_href(href),
        .cmos_frame_vsync(vsync), .max_data(maxData), .bin_data(binData),
        .bin_href(binHref), .bin_vsync(binVsync), .thresh(threshOut),
        .bright_cnt(brightCnt),
`ifdef BBOX_EN
        .bbox_xmin(bxMin), .bbox_xmax(bxMax), .bbox_ymin(byMin), .bbox_ymax(byMax),
`endif
        .frame_done(frameDone)
    );

    frame_thresh_binarize #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .indata(indata), .cmos_frame_href(href),
        .cmos_frame_vsync(vsync), .max_data(maxData), .bin_data(binData4),
        .bin_href(binHref4), .bin_vsync(binVsync4), .thresh(threshOut4),
        .bright_cnt(brightCnt4),
`ifdef BBOX_EN
        .bbox_xmin(bxMin4), .bbox_xmax(bxMax4), .bbox_ymin(byMin4), .bbox_ymax(byMax4),
`endif
        .frame_done(frameDone4)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic h, input logic v, input logic [7:0] d);
        href   = h;
        vsync  = v;
        indata = d;
        tick();
    endtask

    function automatic int modelThresh(input int m);
        int t;
        t = (m * 192) >> 8;
        return (t < 16) ? 16 : t;
    endfunction

    function automatic logic [7:0] pixVal(input int mode, input int x, input int y);
        case (mode)
            0: return 8'd160;
            1: return 8'(15 + (x % 3));
            2: return (((x == 2) && (y == 3)) || ((x == 5) && (y == 6))) ? 8'd255 : 8'd0;
            3: return 8'd0;
            default: return 8'd255;
        endcase
    endfunction

    task automatic vsyncPulse();
        if (mState == 2) begin
            expCntQ.push_back(mCount);
            expCnt4Q.push_back((mCount > 15) ? 15 : mCount);
            expBoxQ.push_back(mxMin);
            expBoxQ.push_back(mxMax);
            expBoxQ.push_back(myMin);
            expBoxQ.push_back(myMax);
            pushCount++;
        end
        mThresh = modelThresh(int'(maxData));
        mState  = 1;
        repeat (3) applyStimulus(1'b0, 1'b1, 8'd0);
        mState = 2;
        mCount = 0;
        mxMin = 2047; mxMax = 0; myMin = 1023; myMax = 0;
        repeat (2) applyStimulus(1'b0, 1'b0, 8'd0);
    endtask

    task automatic sendPixel(input int x, input int y, input logic [7:0] d);
        bit b;
        b = (int'(d) >= mThresh);
        if (mState != 0) expBinQ.push_back(b);
        if ((mState == 2) && b) begin
            mCount++;
            if (x < mxMin) mxMin = x;
            if (x > mxMax) mxMax = x;
            if (y < myMin) myMin = y;
            if (y > myMax) myMax = y;
        end
        applyStimulus(1'b1, 1'b0, d);
    endtask

    task automatic sendLines(input int w, input int h, input int mode, input int changeAt,
                             input logic [7:0] newMax);
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                if ((y * w + x) == changeAt) maxData = newMax;
                sendPixel(x, y, pixVal(mode, x, y));
            end
            repeat (2) applyStimulus(1'b0, 1'b0, 8'd0);
        end
    endtask

    task automatic sendFrame(input int w, input int h, input int mode);
        sendLines(w, h, mode, -1, 8'd0);
        repeat (4) applyStimulus(1'b0, 1'b0, 8'd0);
    endtask

    task automatic doReset();
        rst_n  = 1'b0;
        href   = 1'b0;
        vsync  = 1'b0;
        indata = 8'd0;
        expBinQ.delete();
        mState = 0;
        mCount = 0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset bin_data", binData, 0);
        checkOutput("reset bin_href", binHref, 0);
        checkOutput("reset bin_vsync", binVsync, 0);
        checkOutput("reset thresh", threshOut, 16);
        checkOutput("reset bright_cnt", brightCnt, 0);
        checkOutput("reset frame_done", frameDone, 0);
        rst_n = 1'b1;
        tick();
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) vsHist <= 2'b00;
        else vsHist <= {vsHist[0], vsync};
    end

    // Output monitor: pops the scoreboard whenever the DUTs present a pixel or a frame result.
    always @(negedge clk) begin
        if (rst_n) begin
            if (binHref) begin
                if (expBinQ.size() == 0) checkOutput("bin_href unexpected", binHref, 0);
                else checkOutput("bin_data", binData, int'(expBinQ.pop_front()));
            end else begin
                checkOutput("bin_data without href", binData, 0);
            end
            checkOutput("bin_vsync delay", binVsync, int'(vsHist[1]));
            if (frameDone) begin
                doneSeen++;
                if (expCntQ.size() == 0) begin
                    checkOutput("frame_done unexpected", frameDone, 0);
                end else begin
                    checkOutput("bright_cnt", brightCnt, expCntQ.pop_front());
`ifdef BBOX_EN
                    checkOutput("bbox_xmin", bxMin, expBoxQ[0]);
                    checkOutput("bbox_xmax", bxMax, expBoxQ[1]);
                    checkOutput("bbox_ymin", byMin, expBoxQ[2]);
                    checkOutput("bbox_ymax", byMax, expBoxQ[3]);
`endif
                    repeat (4) void'(expBoxQ.pop_front());
                end
            end
            if (frameDone4) begin
                if (expCnt4Q.size() == 0) checkOutput("frame_done4 unexpected", frameDone4, 0);
                else checkOutput("bright_cnt saturating", brightCnt4, expCnt4Q.pop_front());
            end
        end
    end

    initial begin
        maxData = 8'd200;
        mThresh = 16;
        mxMin = 2047; mxMax = 0; myMin = 1023; myMax = 0;
        doReset();

        vsyncPulse();
        checkOutput("thresh max200", threshOut, 150);
        sendFrame(4, 4, 0);

        maxData = 8'd10;
        vsyncPulse();
        checkOutput("thresh floor", threshOut, 16);
        sendFrame(4, 3, 1);

        maxData = 8'd200;
        vsyncPulse();
        checkOutput("thresh frame3", threshOut, 150);
        sendLines(4, 4, 0, 6, 8'd100);
        repeat (4) applyStimulus(1'b0, 1'b0, 8'd0);
        checkOutput("thresh held mid-frame", threshOut, 150);

        vsyncPulse();
        checkOutput("thresh max100", threshOut, 75);
        sendFrame(5, 4, 4);
        vsyncPulse();

        sendLines(4, 2, 0, -1, 8'd0);
        doReset();
        sendLines(4, 2, 0, -1, 8'd0);
        checkOutput("idle bin_href", binHref, 0);

        maxData = 8'd200;
        vsyncPulse();
        checkOutput("thresh after reset", threshOut, 150);
        sendFrame(8, 8, 2);
        vsyncPulse();
        sendFrame(8, 8, 3);
        vsyncPulse();

        for (int i = 0; (i < 50) && ((expCntQ.size() != 0) || (expCnt4Q.size() != 0)
                                     || (expBinQ.size() != 0)); i++) begin
            tick();
        end
        checkOutput("drain pixel queue", expBinQ.size(), 0);
        checkOutput("drain count queue", expCntQ.size(), 0);
        checkOutput("drain saturating queue", expCnt4Q.size(), 0);
        checkOutput("frame_done pulses", doneSeen, pushCount);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frame_thresh_binarize.md
Name: frame_thresh_binarize

Overview:
- Downstream consumer of the running peak-intensity tracker's `max_data` output.
- Binarizes the 8-bit grayscale CMOS pixel stream against an adaptive threshold derived from `max_data`. The threshold is latched once per frame.
- Produces a binary pixel stream with delayed sync signals, plus a per-frame bright-pixel count for the downstream detection/display logic.

Parameters:
- THRESH_NUM, 192: threshold ratio numerator over 256; threshold = (max_data*THRESH_NUM)>>8.
- MIN_THRESH, 16: floor applied when the computed threshold is below it.
- CNT_W, 20: width of the bright-pixel counter. Must hold 640x480.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous reset, active-low
- indata  in  8  grayscale pixel, valid when cmos_frame_href=1
- cmos_frame_href  in  1  line-valid strobe
- cmos_frame_vsync  in  1  frame sync, active-high pulse between frames
- max_data  in  8  peak intensity from the upstream tracker
- bin_data  out  1  binarized pixel
- bin_href  out  1  href delayed to align with bin_data
- bin_vsync  out  1  vsync delayed to align with bin_data
- thresh  out  8  threshold in use for the current frame
- bright_cnt  out  CNT_W  bright-pixel count of the last completed frame
- frame_done  out  1  one-cycle pulse when bright_cnt updates
- (BBOX_EN only) bbox_xmin, bbox_xmax  out  11 each;  bbox_ymin, bbox_ymax  out  10 each

Behaviour:
- Reset (async, rst_n=0): all outputs 0; thresh=MIN_THRESH; FSM=IDLE; pipeline registers cleared.
- The vsync rising edge is detected with a one-cycle registered copy of cmos_frame_vsync.
- FSM states:
  - IDLE: wait for the first vsync rise. Go to SYNC. Stream data before it is discarded; bin_href is forced 0.
  - SYNC: vsync high. Go to ACTIVE on the vsync fall.
  - ACTIVE: binarize and count.
  - DONE: entered on a vsync rise from ACTIVE. Lasts exactly one cycle, then goes to SYNC.
- On every vsync rise, in any state except reset:
  - t = (max_data*THRESH_NUM)>>8, computed in 16-bit.
  - thresh <= (t < MIN_THRESH) ? MIN_THRESH : t.
  - Changes of max_data mid-frame have no effect until the next vsync rise.
- DONE cycle:
  - bright_cnt <= running count; frame_done=1; running count cleared.
  - Coming from ACTIVE means at least one full frame has been processed. The first partial frame after reset never produces frame_done.
- Pipeline, fixed latency of 2 cycles from indata/href/vsync to bin_data/bin_href/bin_vsync:
  - Stage 1 registers indata, href and vsync.
  - Stage 2 registers the compare result: bin_data = href_d1 & (pix_d1 >= thresh).
  - bin_data=0 whenever bin_href=0.
- Running count increments in ACTIVE for each stage-2 pixel with bin_data=1. It saturates at 2^CNT_W-1 and does not wrap.
- Simultaneous events:
  - vsync rise in the same cycle as href=1: the pixel is dropped from the count. bin_href for that pixel still follows the pipeline.
  - A pixel inside the DONE cycle is not counted.
- Reset mid-frame: immediately returns to IDLE. The next complete frame is the first one reported.
- The threshold compare uses the registered thresh, never the combinational t.

Optional Feature:
- BBOX_EN:
  - Defined: adds x (pixel-in-line) and y (line-in-frame) counters.
    - x resets on the href fall. y increments on the href fall and resets at the vsync rise.
    - Tracks min/max x,y of bright pixels in ACTIVE.
    - Results are published to the bbox_* ports in DONE, together with bright_cnt.
    - Zero bright pixels reports xmin=ymin=all-ones, xmax=ymax=0.
    - bbox_* reset to 0.
  - Undefined: bbox ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package `cmos_pkg`: FSM state enum (IDLE, SYNC, ACTIVE, DONE), pixel width 8, X_W=11, Y_W=10, and defaults for THRESH_NUM/MIN_THRESH.
- One natural sub-module: `sync_edge_det`, a registered rise/fall detector for vsync and href, reused by other camera-stream stages.

Test Plan:
- Reset then frame 1 with max_data=200, 4x4 frame all pixels 160 → thresh=150 after the first vsync rise; bin_data=1 for all 16 pixels, 2-cycle latency; at the next vsync rise frame_done pulses once, bright_cnt=16.
- max_data=10 → thresh=MIN_THRESH=16; pixels 15/16/17 → bin_data 0/1/1.
- max_data changes 200→100 mid-frame → thresh stays 150 until the next vsync rise, then 75.
- Stream starts mid-frame after reset → no frame_done for the partial frame; the first frame_done comes after one full frame.
- Force the count past 2^CNT_W-1 (CNT_W overridden to 4, 20 bright pixels) → bright_cnt=15.
- BBOX_EN, 8x8 frame with bright pixels at (2,3) and (5,6) → bbox_xmin=2, bbox_xmax=5, bbox_ymin=3, bbox_ymax=6 at frame_done; an all-dark frame reports 2047/0/1023/0.
